// File: rtl/mem_arbiter.sv
// Round-robin memory arbiter with lockable grants, bank power gating and an
// in-order read tag pipeline that steers memory responses back to requesters.
module mem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int BANK_W  = 5,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [NUM_REQ*BANK_W-1:0]  req_bank,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic                       rsp_err,
  output logic [DATA_W-1:0]          rsp_data,
  input  logic [(2**BANK_W)-1:0]     bank_power_en,
  output logic                       mem_we,
  output logic                       mem_re,
  output logic [BANK_W-1:0]          mem_bank_sel,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_rsp_valid,
  input  logic [DATA_W-1:0]          mem_rsp_data,
  output logic                       dbg_state
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_owner, w_owner_nxt;
  logic [ID_W-1:0]     r_rr_ptr, w_rr_nxt;
  logic [3:0]          r_lock_cnt, w_lock_cnt_nxt;

  logic                w_grant;
  logic [ID_W-1:0]     w_gidx;
  logic [ID_W:0]       w_sum;

  logic [BANK_W-1:0]   w_bank_a  [NUM_REQ];
  logic [ADDR_W-1:0]   w_addr_a  [NUM_REQ];
  logic [DATA_W-1:0]   w_wdata_a [NUM_REQ];
  logic [BANK_W-1:0]   w_acc_bank;
  logic                w_acc_pwr, w_acc_we, w_acc_lock;

  logic                r_mem_we, r_mem_re;
  logic [BANK_W-1:0]   r_mem_bank;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                r_tag_v   [RD_LAT+1];
  logic [ID_W-1:0]     r_tag_id  [RD_LAT+1];
  logic                r_tag_err [RD_LAT+1];
  logic                w_fire;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_bank_a[i]  = req_bank[i*BANK_W +: BANK_W];
      w_addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
      w_wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Handshake: a request on port i is accepted in exactly the cycles where
  // req_valid[i] and req_ready[i] are both high; req_ready is one-hot or zero
  // and never depends on req_ready itself, only on req_valid and FSM state.
  always_comb begin
    w_grant = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    if (!rst) begin
      if (r_state == S_LOCKED) begin
        w_grant = req_valid[r_owner];
        w_gidx  = r_owner;
      end else begin
        // Walk downward so the port closest to r_rr_ptr is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
          if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
          if (req_valid[w_sum[ID_W-1:0]]) begin
            w_grant = 1'b1;
            w_gidx  = w_sum[ID_W-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    req_ready  = w_grant ? (NUM_REQ'(1) << w_gidx) : '0;
    w_acc_bank = w_bank_a[w_gidx];
    w_acc_pwr  = bank_power_en[w_acc_bank];
    w_acc_we   = req_we[w_gidx];
    w_acc_lock = req_lock[w_gidx];
    dbg_state  = r_state;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_lock_cnt_nxt = '0;
    w_rr_nxt       = r_rr_ptr;
    if (w_grant) w_rr_nxt = (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_grant && w_acc_lock) begin
          w_state_nxt = S_LOCKED;
          w_owner_nxt = w_gidx;
        end
      end
      S_LOCKED: begin
        if (w_grant && !w_acc_lock) begin
          w_state_nxt = S_IDLE;
        end else if (!req_valid[r_owner]) begin
          // Sixteenth consecutive idle cycle of the owner releases the lock.
          if (r_lock_cnt == 4'd15) w_state_nxt = S_IDLE;
          else                     w_lock_cnt_nxt = r_lock_cnt + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_bank  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      for (int s = 0; s <= RD_LAT; s++) begin
        r_tag_v[s]   <= 1'b0;
        r_tag_id[s]  <= '0;
        r_tag_err[s] <= 1'b0;
      end
    end else begin
      r_mem_we <= w_grant && w_acc_pwr && w_acc_we;
      r_mem_re <= w_grant && w_acc_pwr && !w_acc_we;
      if (w_grant && w_acc_pwr) begin
        r_mem_bank  <= w_acc_bank;
        r_mem_addr  <= w_addr_a[w_gidx];
        r_mem_wdata <= w_wdata_a[w_gidx];
      end
      // Dropped reads ride the same pipeline so responses stay in accept order.
      r_tag_v[0]   <= w_grant && !w_acc_we;
      r_tag_id[0]  <= w_gidx;
      r_tag_err[0] <= !w_acc_pwr;
      for (int s = 1; s <= RD_LAT; s++) begin
        r_tag_v[s]   <= r_tag_v[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
        r_tag_err[s] <= r_tag_err[s-1];
      end
    end
  end

  always_comb begin
    mem_we       = r_mem_we && !rst;
    mem_re       = r_mem_re && !rst;
    mem_bank_sel = rst ? '0 : r_mem_bank;
    mem_addr     = rst ? '0 : r_mem_addr;
    mem_wdata    = rst ? '0 : r_mem_wdata;
    w_fire       = !rst && r_tag_v[RD_LAT] && (r_tag_err[RD_LAT] || mem_rsp_valid);
    rsp_valid    = w_fire ? (NUM_REQ'(1) << r_tag_id[RD_LAT]) : '0;
    rsp_err      = w_fire && r_tag_err[RD_LAT];
    rsp_data     = (w_fire && !r_tag_err[RD_LAT]) ? mem_rsp_data : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin order, write-then-read, powered-down
// bank, lock hold/release, lock timeout and reset discarding in-flight reads.
module tb_mem_arbiter;

  localparam int NUM_REQ = 3;
  localparam int BANK_W  = 5;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int RD_LAT  = 2;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid, req_ready, req_we, req_lock;
  logic [NUM_REQ*BANK_W-1:0] req_bank;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic                      rsp_err;
  logic [DATA_W-1:0]         rsp_data;
  logic [(2**BANK_W)-1:0]    bank_power_en;
  logic                      mem_we, mem_re;
  logic [BANK_W-1:0]         mem_bank_sel;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_rsp_valid;
  logic [DATA_W-1:0]         mem_rsp_data;
  logic                      dbg_state;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .NUM_REQ(NUM_REQ), .BANK_W(BANK_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_lock(req_lock), .req_bank(req_bank), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .bank_power_en(bank_power_en),
    .mem_we(mem_we), .mem_re(mem_re), .mem_bank_sel(mem_bank_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .dbg_state(dbg_state)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory controller model: unwritten locations read as (addr ^ 0x5A).
  logic [7:0]   mem_arr [256];
  logic [255:0] wr_flag = '0;
  logic         rd_p0 = 1'b0, rd_p1 = 1'b0;
  logic [7:0]   rd_d0 = '0, rd_d1 = '0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem_arr[mem_addr[7:0]] <= mem_wdata;
      wr_flag[mem_addr[7:0]] <= 1'b1;
    end
    rd_p0 <= mem_re;
    rd_d0 <= wr_flag[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]] : (mem_addr[7:0] ^ 8'h5A);
    rd_p1 <= rd_p0;
    rd_d1 <= rd_d0;
  end

  assign mem_rsp_valid = rd_p1;
  assign mem_rsp_data  = rd_d1;

  // Driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic we, input logic lk,
                          input logic [4:0] bk, input logic [15:0] ad, input logic [7:0] wd);
    req_we[p]              = we;
    req_lock[p]            = lk;
    req_bank[p*BANK_W +: BANK_W]  = bk;
    req_addr[p*ADDR_W +: ADDR_W]  = ad;
    req_wdata[p*DATA_W +: DATA_W] = wd;
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_lock = '0;
    req_bank = '0; req_addr = '0; req_wdata = '0;
    bank_power_en = '1;
    for (int p = 0; p < NUM_REQ; p++) set_port(p, 1'b0, 1'b0, 5'd0, 16'h0100 + 16'(p), 8'h00);

    // Reset: outputs forced low even with requests pending
    step(); step();
    req_valid = 3'b111;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_bank", mem_bank_sel, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_state", dbg_state, 0);

    // Round robin with all three ports reading every cycle
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) rst = 1'b0;
      req_valid = (c < 6) ? 3'b111 : 3'b000;
      #1;
      chk("rr_ready", req_ready, (c < 6) ? (32'd1 << (c % 3)) : 32'd0);
      chk("rr_mem_re", mem_re, (c >= 1 && c <= 6) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 6) chk("rr_mem_addr", mem_addr, 32'h100 + 32'((c - 1) % 3));
      chk("rr_rsp_valid", rsp_valid, (c >= 3 && c <= 8) ? (32'd1 << ((c - 3) % 3)) : 32'd0);
      chk("rr_rsp_data", rsp_data, (c >= 3 && c <= 8) ? 32'(8'((c - 3) % 3) ^ 8'h5A) : 32'd0);
    end

    // Port 1 writes 0xAA to 0x0010, port 2 reads it back next cycle
    step();
    req_valid = 3'b010;
    set_port(1, 1'b1, 1'b0, 5'd0, 16'h0010, 8'hAA);
    #1; chk("raw_ready_w", req_ready, 3'b010);
    step();
    req_valid = 3'b100;
    set_port(1, 1'b0, 1'b0, 5'd0, 16'h0101, 8'h00);
    set_port(2, 1'b0, 1'b0, 5'd0, 16'h0010, 8'h00);
    #1;
    chk("raw_ready_r", req_ready, 3'b100);
    chk("raw_mem_we", mem_we, 1);
    chk("raw_mem_re0", mem_re, 0);
    chk("raw_mem_addr_w", mem_addr, 16'h0010);
    chk("raw_mem_wdata", mem_wdata, 8'hAA);
    step();
    req_valid = 3'b000;
    #1;
    chk("raw_mem_re", mem_re, 1);
    chk("raw_mem_we0", mem_we, 0);
    chk("raw_mem_addr_r", mem_addr, 16'h0010);
    step(); #1;
    chk("raw_rsp_early", rsp_valid, 0);
    step(); #1;
    chk("raw_rsp_valid", rsp_valid, 3'b100);
    chk("raw_rsp_data", rsp_data, 8'hAA);
    chk("raw_rsp_err", rsp_err, 0);
    step(); #1;
    chk("raw_rsp_done", rsp_valid, 0);

    // Bank 4 powered down: write dropped silently, read returns an error
    step();
    bank_power_en[4] = 1'b0;
    req_valid = 3'b001;
    set_port(0, 1'b1, 1'b0, 5'd4, 16'h0030, 8'hDD);
    #1; chk("pd_ready_w", req_ready, 3'b001);
    step();
    req_we[0] = 1'b0;
    #1;
    chk("pd_ready_r", req_ready, 3'b001);
    chk("pd_no_we", mem_we, 0);
    chk("pd_no_re_a", mem_re, 0);
    step();
    req_valid = 3'b000;
    #1;
    chk("pd_no_re_b", mem_re, 0);
    chk("pd_no_we_b", mem_we, 0);
    chk("pd_addr_hold", mem_addr, 16'h0010);
    step(); #1;
    chk("pd_rsp_early", rsp_valid, 0);
    step(); #1;
    chk("pd_rsp_valid", rsp_valid, 3'b001);
    chk("pd_rsp_err", rsp_err, 1);
    chk("pd_rsp_data", rsp_data, 0);
    step(); #1;
    chk("pd_rsp_done", rsp_valid, 0);
    chk("pd_err_done", rsp_err, 0);
    bank_power_en = '1;
    set_port(0, 1'b0, 1'b0, 5'd0, 16'h0100, 8'h00);

    // Port 2 locked for four reads while ports 0 and 1 keep requesting
    step();
    req_valid = 3'b010;
    #1; chk("lk_pre_ready", req_ready, 3'b010);
    step();
    req_valid = 3'b111;
    set_port(2, 1'b0, 1'b1, 5'd0, 16'h0102, 8'h00);
    #1;
    chk("lk_g0_ready", req_ready, 3'b100);
    chk("lk_g0_state", dbg_state, 0);
    step(); #1;
    chk("lk_g1_ready", req_ready, 3'b100);
    chk("lk_g1_state", dbg_state, 1);
    step(); #1;
    chk("lk_g2_ready", req_ready, 3'b100);
    chk("lk_pre_rsp", rsp_valid, 3'b010);
    chk("lk_pre_data", rsp_data, 8'h5B);
    step();
    req_lock[2] = 1'b0;
    #1;
    chk("lk_g3_ready", req_ready, 3'b100);
    chk("lk_g3_rsp", rsp_valid, 3'b100);
    chk("lk_g3_data", rsp_data, 8'h58);
    step(); #1;
    chk("lk_g4_ready", req_ready, 3'b001);
    chk("lk_g4_state", dbg_state, 0);
    step(); #1;
    chk("lk_g5_ready", req_ready, 3'b010);
    step();
    req_valid = 3'b000;
    repeat (4) step();

    // Port 1 locks then goes quiet; lock expires after 16 idle cycles
    req_valid = 3'b010;
    req_lock[1] = 1'b1;
    #1; chk("to_lock_ready", req_ready, 3'b010);
    for (int i = 1; i <= 16; i++) begin
      step();
      req_valid = 3'b001;
      req_lock = '0;
      #1;
      chk("to_blocked", req_ready, 0);
      chk("to_locked_state", dbg_state, 1);
    end
    step(); #1;
    chk("to_release_ready", req_ready, 3'b001);
    chk("to_release_state", dbg_state, 0);
    step();
    req_valid = 3'b000;
    repeat (4) step();

    // Reset right after two reads: their responses must be discarded
    req_valid = 3'b011;
    #1; chk("rs_k0_ready", req_ready, 3'b010);
    step(); #1;
    chk("rs_k1_ready", req_ready, 3'b001);
    step();
    rst = 1'b1;
    #1;
    chk("rs_ready", req_ready, 0);
    chk("rs_mem_re", mem_re, 0);
    chk("rs_mem_we", mem_we, 0);
    chk("rs_mem_addr", mem_addr, 0);
    chk("rs_mem_bank", mem_bank_sel, 0);
    chk("rs_mem_wdata", mem_wdata, 0);
    chk("rs_rsp_valid", rsp_valid, 0);
    chk("rs_rsp_err", rsp_err, 0);
    chk("rs_rsp_data", rsp_data, 0);
    step();
    rst = 1'b0;
    req_valid = 3'b001;
    #1;
    chk("rs_first_grant", req_ready, 3'b001);
    chk("rs_drop_a", rsp_valid, 0);
    step();
    req_valid = 3'b000;
    #1;
    chk("rs_drop_b", rsp_valid, 0);
    chk("rs_new_re", mem_re, 1);
    step(); #1;
    chk("rs_drop_c", rsp_valid, 0);
    step(); #1;
    chk("rs_new_rsp", rsp_valid, 3'b001);
    chk("rs_new_data", rsp_data, 8'h5A);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requester ports, 2..8.
REQ-002 Parameter BANK_W, default 5: bank-select width.
REQ-003 Parameter ADDR_W, default 16: address width.
REQ-004 Parameter DATA_W, default 8: data width.
REQ-005 Parameter RD_LAT, default 2: cycles from mem_re strobe to mem_rsp_valid.
REQ-006 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-007 clk  in  1  rising-edge clock for all state.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 req_valid  in  NUM_REQ  per-requester request pending.
REQ-010 req_ready  out  NUM_REQ  one-hot; request accepted this cycle.
REQ-011 req_we  in  NUM_REQ  1 = write, 0 = read.
REQ-012 req_lock  in  NUM_REQ  hold grant after this request.
REQ-013 req_bank  in  NUM_REQ*BANK_W  packed bank selects, port i at [i*BANK_W +: BANK_W].
REQ-014 req_addr  in  NUM_REQ*ADDR_W  packed addresses.
REQ-015 req_wdata  in  NUM_REQ*DATA_W  packed write data.
REQ-016 rsp_valid  out  NUM_REQ  one-hot read-response strobe.
REQ-017 rsp_err  out  1  response targets a powered-down bank.
REQ-018 rsp_data  out  DATA_W  read data, shared by all ports.
REQ-019 bank_power_en  in  2**BANK_W  per-bank power enable.
REQ-020 mem_we, mem_re  out  1 each  single-cycle strobes to the memory controller.
REQ-021 mem_bank_sel, mem_addr, mem_wdata  out  BANK_W, ADDR_W, DATA_W  registered request fields.
REQ-022 mem_rsp_valid, mem_rsp_data  in  1, DATA_W  memory controller response.

Function
REQ-023 A request on port i is accepted only in a cycle where req_valid[i] and req_ready[i] are both 1; at most one req_ready bit is high per cycle.
REQ-024 req_ready SHALL be combinational from req_valid and arbiter state, so a grant is possible on every cycle (throughput one request per cycle).
REQ-025 Arbitration is round-robin: search starts at port rr_ptr and proceeds upward with wrap; after an accept from port i, rr_ptr becomes (i+1) mod NUM_REQ.
REQ-026 FSM states: IDLE (round-robin) and LOCKED(owner).
REQ-027 IDLE -> LOCKED(i) when port i is accepted with req_lock[i]=1.
REQ-028 In LOCKED(i) only port i may be granted; -> IDLE when port i is accepted with req_lock[i]=0, or when req_valid[i]=0 for 16 consecutive cycles (lock timeout).
REQ-029 An accepted request to a bank with bank_power_en=1 SHALL drive mem_we or mem_re high for exactly the next cycle, with mem_bank_sel, mem_addr and mem_wdata registered from the accepted port.
REQ-030 An accepted request to a powered-down bank SHALL NOT strobe mem_we or mem_re. A dropped write is silent. A dropped read produces rsp_valid[i]=1, rsp_err=1 and rsp_data=0 exactly RD_LAT+1 cycles after accept, in order with other responses.
REQ-031 A read tag pipeline of depth RD_LAT+1 carries {valid, port id, err}. For an issued read, rsp_valid[id] is asserted in the same cycle as mem_rsp_valid, and rsp_data equals mem_rsp_data.
REQ-032 mem_rsp_valid arriving while the pipeline-head tag is invalid SHALL be ignored.
REQ-033 Reads and writes from all ports are issued strictly in acceptance order. Read-after-write to the same address returns the new data without extra stalls.
REQ-034 When mem_we and mem_re are both 0, mem_bank_sel, mem_addr and mem_wdata hold their previous values.

Reset
REQ-035 While rst=1: req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, mem_we=0, mem_re=0, mem_bank_sel/mem_addr/mem_wdata=0, rr_ptr=0, FSM=IDLE, all tags invalid, lock-timeout counter=0.
REQ-036 Reset mid-operation discards in-flight reads: memory responses arriving after reset deasserts for issued reads produce no rsp_valid.
REQ-037 The first grant is possible in the first cycle after rst deasserts.

Verification
REQ-038 Ports 0, 1 and 2 all request reads every cycle, all banks powered -> grant order 0,1,2,0,1,2, one mem_re per cycle, each rsp_valid on the correct port RD_LAT+1 cycles after its accept.
REQ-039 Port 1 writes 0xAA to bank 0 addr 0x0010, then port 2 reads it on the next cycle -> single mem_we, then mem_re; port 2 receives rsp_data=0xAA with rsp_err=0.
REQ-040 bank_power_en[4]=0; port 0 writes 0xDD then reads bank 4 addr 0x0030 -> no mem_we or mem_re; rsp_valid[0]=1, rsp_err=1, rsp_data=0 three cycles after the read accept.
REQ-041 Port 2 issues 4 reads with req_lock=1,1,1,0 while ports 0 and 1 request continuously -> four consecutive grants to port 2, then round-robin resumes at port 0.
REQ-042 Port 1 locks, then deasserts req_valid -> after 16 idle cycles the FSM returns to IDLE and port 0 is granted.
REQ-043 rst pulsed one cycle after two reads are issued -> no rsp_valid for either read; all outputs are 0 during reset.
